ttl_pseudo_clk_gen: RTL



---
 rtl/ttl_pseudo_clk_gen.sv | 58 +++++
 1 files changed

// File: rtl/ttl_pseudo_clk_gen.sv
// ttl_pseudo_clk_gen: NUM/DEN fractional pseudo-clock with rise/fall strobes; TTL_PCLK_DBGCNT_EN adds rise_cnt
module ttl_pseudo_clk_gen #(
   parameter int NUM = 1,
   parameter int DEN = 4,
   parameter int CW  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        sync,
   output logic        pclk,
   output logic        pclk_rise,
   output logic        pclk_fall
`ifdef TTL_PCLK_DBGCNT_EN
   ,
   output logic [15:0] rise_cnt
`endif
);
   logic [CW-1:0] acc;
   logic [CW-1:0] acc_nxt;
   logic [CW:0]   s;
   logic          due;
   if (NUM < 1 || 2 * NUM > DEN) begin : g_bad_ratio
      $error("ttl_pseudo_clk_gen: illegal ratio NUM=%0d DEN=%0d", NUM, DEN);
   end
   always_comb begin
      s       = {1'b0, acc} + (CW+1)'(2 * NUM);
      due     = s >= (CW+1)'(DEN);
      acc_nxt = due ? CW'(s - (CW+1)'(DEN)) : s[CW-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         pclk      <= 1'b0;
         pclk_rise <= 1'b0;
         pclk_fall <= 1'b0;
      end else if (sync) begin
         acc       <= '0;
         pclk      <= 1'b0;
         pclk_rise <= 1'b0;
         pclk_fall <= pclk;
      end else if (run) begin
         acc       <= acc_nxt;
         pclk      <= pclk ^ due;
         pclk_rise <= due & ~pclk;
         pclk_fall <= due & pclk;
      end else begin
         pclk_rise <= 1'b0;
         pclk_fall <= 1'b0;
      end
   end
`ifdef TTL_PCLK_DBGCNT_EN
   always_ff @(posedge clk) begin
      if (rst) rise_cnt <= '0;
      else rise_cnt <= rise_cnt + 16'(pclk_rise);
   end
`endif
endmodule
